// File: rtl/feature_loader_ctrl.sv
// Aligned feature loader sequencer: fetches each output column word by word from SRAM,
// hands words to the loader with their feeder offset, then handshakes the column to the array.
// Optional stall counter port is built only when FL_CTRL_PERF_EN is defined.
module feature_loader_ctrl #(
   parameter int aflDimY      = 128,
   parameter int inputWidth   = 32,
   parameter int elementWidth = 4,
   parameter int kernelWidth  = 3,
   parameter int addrWidth    = 16,
   parameter int colWidth     = 10,
   localparam int inputElements = inputWidth / elementWidth,
   localparam int numFeeders    = aflDimY / kernelWidth,
   localparam int wordsPerCol   = (numFeeders + inputElements - 1) / inputElements,
   localparam int offW          = $clog2(numFeeders)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start_i,
   input  logic [addrWidth-1:0]  cfg_base_i,
   input  logic [colWidth-1:0]   cfg_cols_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  mem_req_o,
   output logic [addrWidth-1:0]  mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [inputWidth-1:0] mem_rdata_i,
   output logic                  afl_valid_o,
   output logic [inputWidth-1:0] afl_data_o,
   output logic [offW-1:0]       afl_offset_o,
   output logic                  col_valid_o,
   input  logic                  col_ready_i
`ifdef FL_CTRL_PERF_EN
   ,
   output logic [31:0]           stall_cycles_o
`endif
);

   localparam int wordW = (wordsPerCol > 1) ? $clog2(wordsPerCol) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_LOAD, S_COL, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [addrWidth-1:0]  base_q;
   logic [colWidth-1:0]   cols_q;
   logic [colWidth-1:0]   col_q;
   logic [wordW-1:0]      word_q;
   logic [inputWidth-1:0] data_q;
   logic [offW-1:0]       offset_q;
   logic                  zero_hold_q;
   logic                  word_last;
   logic                  col_last;
   logic [addrWidth-1:0]  addr_calc;

   assign word_last = (word_q == wordW'(wordsPerCol - 1));
   assign col_last  = (col_q == cols_q - colWidth'(1));
   // Address arithmetic deliberately truncates so the read window wraps around the SRAM.
   assign addr_calc = base_q + addrWidth'(int'(col_q) * wordsPerCol) + addrWidth'(word_q);

   assign afl_data_o   = data_q;
   assign afl_offset_o = offset_q;
   assign mem_addr_o   = mem_req_o ? addr_calc : '0;

   always_comb begin
      state_d     = state_q;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      mem_req_o   = 1'b0;
      afl_valid_o = 1'b0;
      col_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = (cfg_cols_i == '0) ? S_DONE : S_REQ;
         end
         S_REQ: begin
            busy_o    = 1'b1;
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            busy_o = 1'b1;
            if (mem_rvalid_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            busy_o      = 1'b1;
            afl_valid_o = 1'b1;
            state_d     = word_last ? S_COL : S_REQ;
         end
         S_COL: begin
            busy_o      = 1'b1;
            col_valid_o = 1'b1;
            if (col_ready_i) state_d = col_last ? S_DONE : S_REQ;
         end
         S_DONE: begin
            // An empty job spends one extra busy cycle here so done lands two cycles after start.
            if (zero_hold_q) begin
               busy_o = 1'b1;
            end else begin
               done_o  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         cols_q      <= '0;
         col_q       <= '0;
         word_q      <= '0;
         data_q      <= '0;
         offset_q    <= '0;
         zero_hold_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  base_q      <= cfg_base_i;
                  cols_q      <= cfg_cols_i;
                  col_q       <= '0;
                  word_q      <= '0;
                  zero_hold_q <= (cfg_cols_i == '0);
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  data_q   <= mem_rdata_i;
                  offset_q <= offW'(int'(word_q) * inputElements);
               end
            end
            S_LOAD: word_q <= word_last ? '0 : word_q + wordW'(1);
            S_COL: begin
               if (col_ready_i) col_q <= col_q + colWidth'(1);
            end
            S_DONE: zero_hold_q <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef FL_CTRL_PERF_EN
   logic stall_event;

   assign stall_event = ((state_q == S_REQ)  && !mem_gnt_i)    ||
                        ((state_q == S_WAIT) && !mem_rvalid_i) ||
                        ((state_q == S_COL)  && !col_ready_i);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cycles_o <= '0;
      end else if ((state_q == S_IDLE) && start_i) begin
         stall_cycles_o <= '0;
      end else if (stall_event && (stall_cycles_o != '1)) begin
         stall_cycles_o <= stall_cycles_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_feature_loader_ctrl.sv
// Randomized bench for feature_loader_ctrl: bench-side SRAM/array responders, a reference
// stream of {address, data, offset} records per job, and scenario tasks with inline checks.
module tb_feature_loader_ctrl;

   localparam int REC_W = 16 + 32 + 6;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        start_i = 1'b0;
   logic [15:0] cfg_base_i = '0;
   logic [9:0]  cfg_cols_i = '0;
   logic        busy_o, done_o, mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        afl_valid_o;
   logic [31:0] afl_data_o;
   logic [5:0]  afl_offset_o;
   logic        col_valid_o;
   logic        col_ready_i = 1'b0;
`ifdef FL_CTRL_PERF_EN
   logic [31:0] stall_cycles_o;
`endif

   feature_loader_ctrl dut (
      .clk(clk), .nrst(nrst), .start_i(start_i),
      .cfg_base_i(cfg_base_i), .cfg_cols_i(cfg_cols_i),
      .busy_o(busy_o), .done_o(done_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .afl_valid_o(afl_valid_o), .afl_data_o(afl_data_o), .afl_offset_o(afl_offset_o),
      .col_valid_o(col_valid_o), .col_ready_i(col_ready_i)
`ifdef FL_CTRL_PERF_EN
      , .stall_cycles_o(stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   logic [58:0] all_outs;
   assign all_outs = {busy_o, done_o, mem_req_o, mem_addr_o, afl_valid_o,
                      afl_data_o, afl_offset_o, col_valid_o};

   int checks = 0;
   int errors = 0;

   logic [31:0]      data_seed;
   logic [REC_W-1:0] exp_q[$];
   logic [REC_W-1:0] obs_q[$];
   logic [15:0]      obs_addr_q[$];
   logic [31:0]      obs_data_q[$];
   logic [5:0]       obs_off_q[$];
   int done_cnt, done_cyc, busy_cnt, col_hs, col_max_run, addr_unstable, req_cnt;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'hA5C3, ~a} ^ data_seed;
   endfunction

   // Reference: job loads cols*6 words, word w of column c sits at base+6c+w (mod 64K),
   // and lands at feeder offset 8w.
   task automatic build_model(input logic [15:0] base, input int cols);
      exp_q.delete();
      for (int c = 0; c < cols; c++) begin
         for (int w = 0; w < 6; w++) begin
            logic [15:0] a;
            a = 16'((int'(base) + c * 6 + w) % 65536);
            exp_q.push_back({a, mem_word(a), 6'(w * 8)});
         end
      end
   endtask

   function automatic int job_cycles(input int cols, input int g, input int r, input int rd);
      return (cols == 0) ? 2 : cols * (6 * (3 + g + r) + 1 + rd) + 1;
   endfunction

   // Runs one job: SRAM grants after g wait cycles, answers r cycles into WAIT,
   // array accepts a column after rd cycles (rd == 0: ready tied high).
   task automatic run_job(input logic [15:0] base, input logic [9:0] cols,
                          input int g, input int r, input int rd, input int inj_cyc);
      int cyc = 0, post_done = 0, req_wait = 0, col_wait = 0, col_run = 0;
      int pend_cnt = 0;
      bit pend = 0;
      logic [15:0] pend_addr = '0, req_addr = '0;
      obs_addr_q.delete(); obs_data_q.delete(); obs_off_q.delete(); obs_q.delete();
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; col_hs = 0; col_max_run = 0;
      addr_unstable = 0; req_cnt = 0;
      @(negedge clk);
      start_i = 1'b1; cfg_base_i = base; cfg_cols_i = cols;
      while (post_done < 3 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start_i = (cyc == inj_cyc);
         if (cyc == inj_cyc) begin
            cfg_base_i = base ^ 16'h0F0F; cfg_cols_i = cols + 10'd1;
         end
         mem_rvalid_i = 1'b0; mem_rdata_i = '0;
         if (pend) begin
            if (pend_cnt == r) begin
               mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(pend_addr); pend = 0;
            end else pend_cnt++;
         end
         mem_gnt_i = 1'b0;
         if (mem_req_o) begin
            if (req_wait == 0) begin
               obs_addr_q.push_back(mem_addr_o); req_cnt++;
            end else if (mem_addr_o !== req_addr) addr_unstable++;
            req_addr = mem_addr_o;
            if (req_wait >= g) begin
               mem_gnt_i = 1'b1; pend = 1; pend_cnt = 0; pend_addr = mem_addr_o; req_wait = 0;
            end else req_wait++;
         end
         if (afl_valid_o) begin
            obs_data_q.push_back(afl_data_o); obs_off_q.push_back(afl_offset_o);
         end
         col_ready_i = (rd == 0);
         if (col_valid_o) begin
            col_run++;
            if (col_run > col_max_run) col_max_run = col_run;
            if (rd == 0 || col_wait >= rd) begin
               col_ready_i = 1'b1; col_hs++; col_wait = 0;
            end else col_wait++;
         end else col_run = 0;
         if (busy_o) busy_cnt++;
         if (done_o) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
         end
         if (done_cnt > 0) post_done++;
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; col_ready_i = 1'b0; start_i = 1'b0;
      for (int i = 0; i < obs_data_q.size(); i++)
         obs_q.push_back({(i < obs_addr_q.size()) ? obs_addr_q[i] : 16'hxxxx,
                          obs_data_q[i], obs_off_q[i]});
   endtask

   task automatic test_reset;
      nrst = 1'b1;
      #2 nrst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL reset_outs: got %h, expected 0", all_outs);
      end
`ifdef FL_CTRL_PERF_EN
      checks++;
      if (stall_cycles_o !== 32'd0) begin
         errors++; $display("FAIL reset_stall: got %0d, expected 0", stall_cycles_o);
      end
`endif
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL idle_outs: got %h, expected 0", all_outs);
      end
   endtask

   task automatic test_zero_wait;
      data_seed = $urandom;
      build_model(16'h0100, 1);
      run_job(16'h0100, 10'd1, 0, 0, 0, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL zw_loads: got %0d, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL zw_word%0d: got addr=%h data=%h off=%0d, expected addr=%h data=%h off=%0d",
                     i, obs_q[i][53:38], obs_q[i][37:6], obs_q[i][5:0],
                     exp_q[i][53:38], exp_q[i][37:6], exp_q[i][5:0]);
         end
      end
      checks++;
      if (done_cyc != 20 || done_cnt != 1) begin
         errors++; $display("FAIL zw_done: got cycle %0d count %0d, expected cycle 20 count 1", done_cyc, done_cnt);
      end
      checks++;
      if (busy_cnt != 19) begin
         errors++; $display("FAIL zw_busy: got %0d busy cycles, expected 19", busy_cnt);
      end
   endtask

   task automatic test_multi_col;
      data_seed = $urandom;
      build_model(16'h0000, 3);
      run_job(16'h0000, 10'd3, 0, 0, 0, 0);
      checks++;
      if (obs_q.size() != 18) begin
         errors++; $display("FAIL mc_loads: got %0d, expected 18", obs_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mc_word%0d: got addr=%h data=%h off=%0d, expected addr=%h data=%h off=%0d",
                     i, obs_q[i][53:38], obs_q[i][37:6], obs_q[i][5:0],
                     exp_q[i][53:38], exp_q[i][37:6], exp_q[i][5:0]);
         end
      end
      checks++;
      if (col_hs != 3 || done_cnt != 1 || done_cyc != job_cycles(3, 0, 0, 0)) begin
         errors++;
         $display("FAIL mc_cols: got %0d columns, %0d dones at %0d, expected 3 columns, 1 done at %0d",
                  col_hs, done_cnt, done_cyc, job_cycles(3, 0, 0, 0));
      end
   endtask

   task automatic test_backpressure;
      data_seed = $urandom;
      build_model(16'h0420, 1);
      run_job(16'h0420, 10'd1, 4, 3, 5, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_word%0d: got %h, expected %h",
                               i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      checks++;
      if (addr_unstable != 0) begin
         errors++; $display("FAIL bp_addr_stable: got %0d changes, expected 0", addr_unstable);
      end
      checks++;
      if (col_max_run != 6) begin
         errors++; $display("FAIL bp_col_valid: got %0d cycles high, expected 6", col_max_run);
      end
      checks++;
      if (done_cyc != job_cycles(1, 4, 3, 5) || done_cnt != 1) begin
         errors++; $display("FAIL bp_done: got cycle %0d count %0d, expected cycle %0d count 1",
                            done_cyc, done_cnt, job_cycles(1, 4, 3, 5));
      end
`ifdef FL_CTRL_PERF_EN
      checks++;
      if (stall_cycles_o !== 32'd47) begin
         errors++; $display("FAIL bp_stall: got %0d, expected 47", stall_cycles_o);
      end
`endif
   endtask

   task automatic test_addr_wrap;
      data_seed = $urandom;
      build_model(16'hFFFE, 1);
      run_job(16'hFFFE, 10'd1, 1, 0, 0, 0);
      checks++;
      if (obs_addr_q.size() != 6) begin
         errors++; $display("FAIL wrap_reqs: got %0d, expected 6", obs_addr_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL wrap_word%0d: got addr=%h, expected addr=%h",
                               i, obs_q[i][53:38], exp_q[i][53:38]);
         end
      end
   endtask

   task automatic test_zero_cols;
      data_seed = $urandom;
      run_job(16'h1234, 10'd0, 0, 0, 0, 0);
      checks++;
      if (done_cyc != 2 || done_cnt != 1) begin
         errors++; $display("FAIL zc_done: got cycle %0d count %0d, expected cycle 2 count 1", done_cyc, done_cnt);
      end
      checks++;
      if (req_cnt != 0 || obs_q.size() != 0 || col_hs != 0) begin
         errors++; $display("FAIL zc_traffic: got %0d reqs %0d loads %0d cols, expected none",
                            req_cnt, obs_q.size(), col_hs);
      end
      checks++;
      if (busy_cnt != 1) begin
         errors++; $display("FAIL zc_busy: got %0d busy cycles, expected 1", busy_cnt);
      end
   endtask

   task automatic test_start_while_busy;
      data_seed = $urandom;
      build_model(16'h0200, 2);
      run_job(16'h0200, 10'd2, 0, 0, 0, 5);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL swb_loads: got %0d, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL swb_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != job_cycles(2, 0, 0, 0)) begin
         errors++; $display("FAIL swb_done: got %0d dones at %0d, expected 1 at %0d",
                            done_cnt, done_cyc, job_cycles(2, 0, 0, 0));
      end
   endtask

   task automatic test_random_jobs;
      for (int j = 0; j < 4; j++) begin
         logic [15:0] base;
         int cols, g, r, rd;
         base = 16'($urandom); cols = $urandom_range(1, 3);
         g = $urandom_range(0, 3); r = $urandom_range(0, 3); rd = $urandom_range(0, 3);
         data_seed = $urandom;
         build_model(base, cols);
         run_job(base, 10'(cols), g, r, rd, 0);
         checks++;
         if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd%0d_loads: got %0d, expected %0d", j, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rnd%0d_word%0d: got %h, expected %h", j, i, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if (done_cnt != 1 || done_cyc != job_cycles(cols, g, r, rd) || col_hs != cols) begin
            errors++; $display("FAIL rnd%0d_done: got %0d dones at %0d, %0d cols, expected 1 at %0d, %0d cols",
                               j, done_cnt, done_cyc, col_hs, job_cycles(cols, g, r, rd), cols);
         end
`ifdef FL_CTRL_PERF_EN
         checks++;
         if (stall_cycles_o !== 32'(cols * (6 * (g + r) + rd))) begin
            errors++; $display("FAIL rnd%0d_stall: got %0d, expected %0d", j, stall_cycles_o,
                               cols * (6 * (g + r) + rd));
         end
`endif
      end
   endtask

   task automatic test_reset_mid_job;
      int reqs = 0;
      bit waiting = 0, hit = 0;
      mem_gnt_i = 1'b1; col_ready_i = 1'b1;
      @(negedge clk);
      start_i = 1'b1; cfg_base_i = 16'h3000; cfg_cols_i = 10'd2;
      for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
         @(negedge clk);
         start_i = 1'b0; mem_rvalid_i = 1'b0;
         if (waiting) begin
            if (reqs == 4) hit = 1;
            else begin
               mem_rvalid_i = 1'b1; mem_rdata_i = $urandom; waiting = 0;
            end
         end
         if (!hit && mem_req_o) begin
            reqs++; waiting = 1;
         end
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL rst_reach_wait: got %0d requests, expected WAIT of word 3", reqs);
      end
      nrst = 1'b0;
      #1;
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL rst_async_outs: got %h, expected 0", all_outs);
      end
      @(negedge clk);
      nrst = 1'b1; mem_gnt_i = 1'b0; col_ready_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      checks++;
      if ({afl_valid_o, busy_o, mem_req_o} !== 3'b000) begin
         errors++; $display("FAIL rst_late_rvalid: got valid/busy/req=%b, expected 000",
                            {afl_valid_o, busy_o, mem_req_o});
      end
      data_seed = $urandom;
      build_model(16'h0040, 1);
      run_job(16'h0040, 10'd1, 0, 0, 0, 0);
      checks++;
      if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
         errors++; $display("FAIL rst_rerun: got %0d loads %0d dones, expected %0d loads 1 done",
                            obs_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rst_rerun_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_multi_col();
      test_backpressure();
      test_addr_wrap();
      test_zero_cols();
      test_start_while_busy();
      test_random_jobs();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/feature_loader_ctrl.md
# feature_loader_ctrl

Sequencer for the aligned feature loader. It fetches input-feature words from the activation SRAM over a request/grant/rvalid port, one output column at a time. Each word is presented to the loader together with the feeder offset that aligns it onto the window-row feeders. A column handshake to the array controller tells it when all feeders hold a complete column.

## Interface
Parameters:
- aflDimY, 128, loader rows
- inputWidth, 32, SRAM word width
- elementWidth, 4, element width
- kernelWidth, 3, kernel width
- addrWidth, 16, SRAM address width
- colWidth, 10, width of the column count
- Derived: inputElements = inputWidth/elementWidth (8); numFeeders = aflDimY/kernelWidth (42); wordsPerCol = ceil(numFeeders/inputElements) (6); offW = $clog2(numFeeders)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; cfg sampled when start_i=1 in IDLE
- cfg_base_i  in  addrWidth  first word address
- cfg_cols_i  in  colWidth  columns to load
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse at job end
- mem_req_o  out  1  read request
- mem_addr_o  out  addrWidth  read address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  inputWidth  read data
- afl_valid_o  out  1  loader load strobe
- afl_data_o  out  inputWidth  word to loader
- afl_offset_o  out  offW  feeder offset in elements
- col_valid_o  out  1  column complete in feeders
- col_ready_i  in  1  array accepted column
- stall_cycles_o  out  32  only with FL_CTRL_PERF_EN

## Operation
- Reset: every output is 0; FSM is in IDLE; counters are 0.
- FSM states: IDLE, REQ, WAIT, LOAD, COL, DONE.
- IDLE: on start_i, latch base and cols.
  - If cols == 0, go to DONE; otherwise go to REQ.
- REQ:
  - mem_req_o = 1 and mem_addr_o = base + col*wordsPerCol + word; this sum wraps modulo 2^addrWidth.
  - Hold both stable until mem_gnt_i, then go to WAIT.
- WAIT: on mem_rvalid_i, register mem_rdata_i and go to LOAD. An rvalid that arrives outside WAIT is ignored.
- LOAD:
  - afl_valid_o = 1; afl_data_o = the latched word; afl_offset_o = word*inputElements.
  - Then increment word. At word == wordsPerCol-1, clear word and go to COL; otherwise go to REQ.
- COL: col_valid_o = 1 until col_ready_i.
  - On the handshake, increment col.
  - If col == cols-1, go to DONE; otherwise go to REQ.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- start_i is ignored outside IDLE.
- Only one read is outstanding at a time.
- afl_data_o and afl_offset_o hold their last values when afl_valid_o = 0.
- Asynchronous reset mid-job returns everything to the reset state immediately. Any pending SRAM response after reset is ignored.

## Timing
- start_i at cycle 0: busy_o = 1 and mem_req_o = 1 at cycle 1.
- mem_gnt_i at cycle t: WAIT from t+1.
- mem_rvalid_i at cycle r: afl_valid_o = 1 at r+1; next mem_req_o at r+2.
- Best case with gnt in the same cycle and rvalid on the next cycle: 3 cycles per word, 18 cycles per column plus the COL handshake cycle.
- col_valid_o rises the cycle after the last LOAD.
- col_ready_i asserted together with col_valid_o completes the handshake in that cycle.
- done_o asserts the cycle after the final column handshake; busy_o falls in that same cycle.
- When cols == 0: done_o at cycle 2, no memory traffic.

## Configuration
- FL_CTRL_PERF_EN defined:
  - stall_cycles_o counts cycles in REQ with mem_gnt_i = 0, WAIT with mem_rvalid_i = 0, and COL with col_ready_i = 0.
  - It clears on an accepted start and saturates at 2^32-1.
- FL_CTRL_PERF_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Zero-wait single column: base = 0x0100, cols = 1, gnt immediate, rvalid next cycle, col_ready_i tied 1.
  - Addresses 0x0100..0x0105; afl_offset_o 0,8,16,24,32,40.
  - Six afl_valid_o pulses carrying the returned data; done_o 20 cycles after start.
- Multi-column addressing: base = 0x0000, cols = 3.
  - Column 2 addresses 0x000C..0x0011; col_valid_o pulses 3 times; done_o once.
- Backpressure: gnt delayed 4 cycles and rvalid delayed 3 cycles per word; col_ready_i held low 5 cycles.
  - mem_addr_o stays stable during each gnt wait; col_valid_o stays high for 6 cycles.
  - With perf enabled: stall_cycles_o = 6*(4+3)+5 = 47.
- Address wrap: base = 0xFFFE, cols = 1. Addresses 0xFFFE, 0xFFFF, 0x0000..0x0003.
- Boundaries: cols = 0 gives done_o at cycle 2 and no mem_req_o; a start_i pulse while busy is ignored (job unchanged, one done_o).
- Reset mid-job: nrst low during WAIT of word 3.
  - All outputs are 0 immediately.
  - A following rvalid produces no afl_valid_o; a new start runs cleanly from word 0.
